// File: rtl/i2s_receiver.sv
// ---------------------------------------------------------------------------
// i2s_receiver
//
// I2S master receiver. Divides mclk down to the bit clock (sclk), generates
// the word select (ws) with the standard one-bit lead ahead of each MSB,
// and captures a WIDTH-bit left and right sample from each frame of
// 2*SLOT_BITS bit clocks. Slot bits beyond WIDTH are padding and ignored.
//
// Parameters:
//   WIDTH     - sample width in bits (1..SLOT_BITS)
//   SLOT_BITS - sclk bits per channel slot (>= 2)
//   SCLK_DIV  - mclk cycles per sclk period (even, >= 4)
//
// Ports:
//   mclk      - in,  master clock, all logic on its rising edge
//   rst       - in,  asynchronous active-low reset
//   sd_rx     - in,  serial data from the codec, MSB first
//   rx_data_l - out, last complete left sample
//   rx_data_r - out, last complete right sample
//   sclk      - out, generated bit clock (50% duty)
//   ws        - out, generated word select (0 = left, 1 = right)
//   rx_valid  - out, one-cycle strobe with each rx_data_r update; present
//               only when the macro I2S_RX_VALID_EN is defined
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module i2s_receiver #(
  parameter int WIDTH     = 16,
  parameter int SLOT_BITS = 32,
  parameter int SCLK_DIV  = 24
) (
  input  logic             mclk,
  input  logic             rst,
  input  logic             sd_rx,
  output logic [WIDTH-1:0] rx_data_l,
  output logic [WIDTH-1:0] rx_data_r,
  output logic             sclk,
  output logic             ws
`ifdef I2S_RX_VALID_EN
  ,
  output logic             rx_valid
`endif
);

  localparam int HALF  = SCLK_DIV / 2;
  localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int FRAME = 2 * SLOT_BITS;
  localparam int B_W   = $clog2(FRAME);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);
  localparam logic [B_W-1:0]   B_LAST   = B_W'(FRAME - 1);
  localparam logic [B_W-1:0]   WS_FIRST = B_W'(SLOT_BITS - 1);
  localparam logic [B_W-1:0]   WS_LAST  = B_W'(FRAME - 2);
  localparam logic [B_W-1:0]   L_LSB    = B_W'(WIDTH - 1);
  localparam logic [B_W-1:0]   R_LSB    = B_W'(SLOT_BITS + WIDTH - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             sclk_q, sclk_d;
  logic [B_W-1:0]   b_q, b_d;
  logic             ws_q, ws_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             latch_l_q, latch_l_d;
  logic             latch_r_q, latch_r_d;
  logic [WIDTH-1:0] rx_data_l_q, rx_data_l_d;
  logic [WIDTH-1:0] rx_data_r_q, rx_data_r_d;
  logic             rx_valid_q, rx_valid_d;

  logic sclk_rise_s;
  logic sclk_fall_s;

  // Bit-clock divider: toggle sclk at each terminal count.
  always_comb begin
    div_d       = div_q;
    sclk_d      = sclk_q;
    sclk_rise_s = 1'b0;
    sclk_fall_s = 1'b0;
    if (div_q == DIV_LAST) begin
      div_d       = '0;
      sclk_d      = ~sclk_q;
      sclk_rise_s = ~sclk_q;
      sclk_fall_s = sclk_q;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // Frame bit index and word select, both advanced on sclk falling toggles.
  // ws is decoded from the upcoming index so it leads each MSB by one bit.
  always_comb begin
    b_d  = b_q;
    ws_d = ws_q;
    if (sclk_fall_s) begin
      if (b_q == B_LAST) begin
        b_d = '0;
      end else begin
        b_d = b_q + B_W'(1);
      end
      ws_d = (b_d >= WS_FIRST) && (b_d <= WS_LAST);
    end else begin
      b_d  = b_q;
      ws_d = ws_q;
    end
  end

  // Data capture: shift on every sclk rise; flag a word boundary when the
  // LSB of a channel lands, and move the word out one mclk later. The shift
  // register holds still between rises, so the delayed copy is exact.
  always_comb begin
    sh_d        = sh_q;
    latch_l_d   = 1'b0;
    latch_r_d   = 1'b0;
    rx_data_l_d = rx_data_l_q;
    rx_data_r_d = rx_data_r_q;
    rx_valid_d  = latch_r_q;
    if (sclk_rise_s) begin
      sh_d      = (sh_q << 1) | WIDTH'(sd_rx);
      latch_l_d = (b_q == L_LSB);
      latch_r_d = (b_q == R_LSB);
    end else begin
      sh_d = sh_q;
    end
    if (latch_l_q) begin
      rx_data_l_d = sh_q;
    end else begin
      rx_data_l_d = rx_data_l_q;
    end
    if (latch_r_q) begin
      rx_data_r_d = sh_q;
    end else begin
      rx_data_r_d = rx_data_r_q;
    end
  end

  // State registers. Reset parks the index at the last frame bit so the
  // first sclk fall after release starts a fresh left slot at b=0.
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      div_q       <= '0;
      sclk_q      <= 1'b0;
      b_q         <= B_LAST;
      ws_q        <= 1'b0;
      sh_q        <= '0;
      latch_l_q   <= 1'b0;
      latch_r_q   <= 1'b0;
      rx_data_l_q <= '0;
      rx_data_r_q <= '0;
      rx_valid_q  <= 1'b0;
    end else begin
      div_q       <= div_d;
      sclk_q      <= sclk_d;
      b_q         <= b_d;
      ws_q        <= ws_d;
      sh_q        <= sh_d;
      latch_l_q   <= latch_l_d;
      latch_r_q   <= latch_r_d;
      rx_data_l_q <= rx_data_l_d;
      rx_data_r_q <= rx_data_r_d;
      rx_valid_q  <= rx_valid_d;
    end
  end

  assign rx_data_l = rx_data_l_q;
  assign rx_data_r = rx_data_r_q;
  assign sclk      = sclk_q;
  assign ws        = ws_q;

`ifdef I2S_RX_VALID_EN
  assign rx_valid = rx_valid_q;
`else
  logic unused_valid_s;
  assign unused_valid_s = rx_valid_q;
`endif

endmodule

// File: tb/tb_i2s_receiver.sv
// ---------------------------------------------------------------------------
// tb_i2s_receiver
//
// Directed bench for i2s_receiver (WIDTH=16, SLOT_BITS=32, SCLK_DIV=24,
// mclk period 20 ns). Serial data is driven from the bench's own mclk count:
// after reset release the sclk fall that starts bit b lands on mclk rising
// edge 24*(b+1), and its sampling rise 12 edges later.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_i2s_receiver;

  localparam int WIDTH     = 16;
  localparam int SLOT_BITS = 32;
  localparam int SCLK_DIV  = 24;

  logic        mclk = 1'b0;
  logic        rst  = 1'b0;
  logic        sd_rx = 1'b0;
  logic [15:0] rx_data_l;
  logic [15:0] rx_data_r;
  logic        sclk;
  logic        ws;
`ifdef I2S_RX_VALID_EN
  logic        rx_valid;
  int          vcount = 0;
`endif

  int errors = 0;
  int checks = 0;
  logic [63:0] fr;

  always #10 mclk = ~mclk;

  i2s_receiver #(
    .WIDTH    (WIDTH),
    .SLOT_BITS(SLOT_BITS),
    .SCLK_DIV (SCLK_DIV)
  ) dut (
    .mclk     (mclk),
    .rst      (rst),
    .sd_rx    (sd_rx),
    .rx_data_l(rx_data_l),
    .rx_data_r(rx_data_r),
    .sclk     (sclk),
`ifdef I2S_RX_VALID_EN
    .ws       (ws),
    .rx_valid (rx_valid)
`else
    .ws       (ws)
`endif
  );

`ifdef I2S_RX_VALID_EN
  always @(posedge mclk) begin
    #1;
    if (rx_valid === 1'b1) vcount++;
  end
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk_frame(input logic [15:0] l, input logic [15:0] r,
                                           input logic p);
    return {l, {16{p}}, r, {16{p}}};
  endfunction

  // Drive frame bits from..to, each one right after its sclk falling edge.
  task automatic send_range(input logic [63:0] f, input int from, input int to);
    for (int b = from; b <= to; b++) begin
      repeat (SCLK_DIV) @(posedge mclk);
      #1 sd_rx = f[63-b];
    end
  endtask

  initial begin
    // Reset state
    sd_rx = 1'b1;
    #35;
    chk("rst_sclk", {31'd0, sclk}, 32'd0);
    chk("rst_ws", {31'd0, ws}, 32'd0);
    chk("rst_l", {16'd0, rx_data_l}, 32'd0);
    chk("rst_r", {16'd0, rx_data_r}, 32'd0);
`ifdef I2S_RX_VALID_EN
    chk("rst_valid", {31'd0, rx_valid}, 32'd0);
`endif

    // Clock generation: first rise 12 mclk after release, first fall 24
    @(negedge mclk) rst = 1'b1;
    repeat (11) @(posedge mclk);
    #1 chk("sclk_low_before_rise", {31'd0, sclk}, 32'd0);
    @(posedge mclk);
    #1 chk("sclk_first_rise", {31'd0, sclk}, 32'd1);
    repeat (11) @(posedge mclk);
    #1 chk("sclk_high_before_fall", {31'd0, sclk}, 32'd1);
    @(posedge mclk);
    #1 chk("sclk_first_fall", {31'd0, sclk}, 32'd0);
    chk("ws_b0", {31'd0, ws}, 32'd0);

    // Stereo capture: left 0x1111, right 0xFFFF, zero padding
    fr = mk_frame(16'h1111, 16'hFFFF, 1'b0);
    sd_rx = fr[63];
    send_range(fr, 1, 15);
    chk("l_no_partial", {16'd0, rx_data_l}, 32'd0);
    send_range(fr, 16, 30);
    chk("l_capture", {16'd0, rx_data_l}, 32'h1111);
    chk("ws_b30", {31'd0, ws}, 32'd0);
    send_range(fr, 31, 31);
    chk("ws_b31_lead", {31'd0, ws}, 32'd1);
    send_range(fr, 32, 47);
    chk("r_no_partial", {16'd0, rx_data_r}, 32'd0);
    send_range(fr, 48, 62);
    chk("r_capture", {16'd0, rx_data_r}, 32'hFFFF);
    chk("ws_b62", {31'd0, ws}, 32'd1);
    send_range(fr, 63, 63);
    chk("ws_b63_lead", {31'd0, ws}, 32'd0);

    // Padding ignored: data zero, padding ones
    fr = mk_frame(16'h0000, 16'h0000, 1'b1);
    send_range(fr, 0, 63);
    chk("pad_l", {16'd0, rx_data_l}, 32'd0);
    chk("pad_r", {16'd0, rx_data_r}, 32'd0);
    chk("pad_ws", {31'd0, ws}, 32'd0);

    // Hold: frame with left 0xA5A5, then 0x5A5A with edge-exact checks
    fr = mk_frame(16'hA5A5, 16'h1234, 1'b0);
    send_range(fr, 0, 63);
    chk("hold_l1", {16'd0, rx_data_l}, 32'hA5A5);
    chk("hold_r1", {16'd0, rx_data_r}, 32'h1234);
`ifdef I2S_RX_VALID_EN
    vcount = 0;
`endif
    fr = mk_frame(16'h5A5A, 16'h4321, 1'b1);
    send_range(fr, 0, 15);
    repeat (12) @(posedge mclk);
    #1 chk("hold_l_at_lsb_sample", {16'd0, rx_data_l}, 32'hA5A5);
    @(posedge mclk);
    #1 chk("l_update_next_mclk", {16'd0, rx_data_l}, 32'h5A5A);
`ifdef I2S_RX_VALID_EN
    chk("valid_low_on_l", {31'd0, rx_valid}, 32'd0);
`endif
    repeat (11) @(posedge mclk);
    #1 sd_rx = fr[63-16];
    send_range(fr, 17, 47);
    repeat (12) @(posedge mclk);
    #1 chk("hold_r_at_lsb_sample", {16'd0, rx_data_r}, 32'h1234);
`ifdef I2S_RX_VALID_EN
    chk("valid_low_before", {31'd0, rx_valid}, 32'd0);
`endif
    @(posedge mclk);
    #1 chk("r_update_next_mclk", {16'd0, rx_data_r}, 32'h4321);
`ifdef I2S_RX_VALID_EN
    chk("valid_pulse", {31'd0, rx_valid}, 32'd1);
`endif
    @(posedge mclk);
`ifdef I2S_RX_VALID_EN
    #1 chk("valid_one_cycle", {31'd0, rx_valid}, 32'd0);
`endif
    repeat (10) @(posedge mclk);
    #1 sd_rx = fr[63-48];
    send_range(fr, 49, 63);
    chk("hold_l2", {16'd0, rx_data_l}, 32'h5A5A);
`ifdef I2S_RX_VALID_EN
    chk("valid_per_frame", vcount, 32'd1);
`endif

    // Reset mid-frame: abort during left bit 8
    fr = mk_frame(16'hBEEF, 16'hC0DE, 1'b0);
    send_range(fr, 0, 8);
    repeat (5) @(posedge mclk);
    #3 rst = 1'b0;
    #2;
    chk("midrst_l", {16'd0, rx_data_l}, 32'd0);
    chk("midrst_r", {16'd0, rx_data_r}, 32'd0);
    chk("midrst_sclk", {31'd0, sclk}, 32'd0);
    chk("midrst_ws", {31'd0, ws}, 32'd0);
    repeat (3) @(posedge mclk);
    @(negedge mclk) rst = 1'b1;
    fr = mk_frame(16'h0F0F, 16'hF0F0, 1'b1);
    send_range(fr, 0, 15);
    chk("post_rst_no_stale", {16'd0, rx_data_l}, 32'd0);
    send_range(fr, 16, 63);
    chk("post_rst_l", {16'd0, rx_data_l}, 32'h0F0F);
    chk("post_rst_r", {16'd0, rx_data_r}, 32'hF0F0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
